// File: rtl/timer_sched.sv
// Two-requester delay scheduler sharing one 16-bit-register interval timer.
// Optional abort inputs are enabled by defining TIMER_SCHED_ABORT_EN.
module timer_sched #(
  parameter int unsigned MIN_PERIOD = 32'd2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_0,
  input  logic        req_1,
  input  logic [31:0] period_0,
  input  logic [31:0] period_1,
`ifdef TIMER_SCHED_ABORT_EN
  input  logic        abort_0,
  input  logic        abort_1,
`endif
  output logic        done_0,
  output logic        done_1,
  output logic        err,
  output logic        busy,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic        tmr_irq
);

  localparam logic [31:0] LP_MIN = 32'(MIN_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARB      = 3'd1,
    S_WR_PL    = 3'd2,
    S_WR_PH    = 3'd3,
    S_WR_CTL   = 3'd4,
    S_WAIT_IRQ = 3'd5,
    S_CLR_ST   = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t      r_state, w_next;
  logic        r_grant, w_grant;
  logic        r_last, w_last;
  logic [31:0] r_period, w_period;
  logic        r_flag, w_flag;
  logic        w_abort;

  logic        r_done_0, r_done_1, r_err, r_busy, r_cs, r_wn;
  logic [2:0]  r_addr;
  logic [15:0] r_wdata;
  logic        w_done_0, w_done_1, w_err, w_busy, w_cs, w_wn;
  logic [2:0]  w_addr;
  logic [15:0] w_wdata;

`ifdef TIMER_SCHED_ABORT_EN
  assign w_abort = r_grant ? abort_1 : abort_0;
`else
  assign w_abort = 1'b0;
`endif

  // State, arbitration context and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_period <= 32'd0;
      r_flag   <= 1'b0;
      r_done_0 <= 1'b0;
      r_done_1 <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_cs     <= 1'b0;
      r_wn     <= 1'b1;
      r_addr   <= 3'd0;
      r_wdata  <= 16'd0;
    end else begin
      r_state  <= w_next;
      r_grant  <= w_grant;
      r_last   <= w_last;
      r_period <= w_period;
      r_flag   <= w_flag;
      r_done_0 <= w_done_0;
      r_done_1 <= w_done_1;
      r_err    <= w_err;
      r_busy   <= w_busy;
      r_cs     <= w_cs;
      r_wn     <= w_wn;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
    end
  end

  // Next-state, round-robin grant and period latch; r_flag marks error or abort
  always_comb begin
    w_next   = r_state;
    w_grant  = r_grant;
    w_last   = r_last;
    w_period = r_period;
    w_flag   = r_flag;
    case (r_state)
      S_IDLE: begin
        w_flag = 1'b0;
        if (req_0 || req_1) w_next = S_ARB;
        else                w_next = S_IDLE;
      end
      S_ARB: begin
        if (req_0 || req_1) begin
          if (req_0 && req_1) w_grant = ~r_last;
          else                w_grant = req_1;
          w_last   = w_grant;
          w_period = w_grant ? period_1 : period_0;
          if (w_period < LP_MIN) begin
            w_flag = 1'b1;
            w_next = S_DONE;
          end else begin
            w_next = S_WR_PL;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WR_PL:  w_next = S_WR_PH;
      S_WR_PH:  w_next = S_WR_CTL;
      S_WR_CTL: begin
        if (r_flag) w_next = S_CLR_ST;
        else        w_next = S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        if (w_abort) begin
          w_flag = 1'b1;
          w_next = S_WR_CTL;
        end else if (tmr_irq) begin
          w_next = S_CLR_ST;
        end else begin
          w_next = S_WAIT_IRQ;
        end
      end
      S_CLR_ST: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    w_cs     = 1'b0;
    w_wn     = 1'b1;
    w_addr   = 3'd0;
    w_wdata  = 16'd0;
    w_done_0 = 1'b0;
    w_done_1 = 1'b0;
    w_err    = 1'b0;
    w_busy   = (w_next != S_IDLE);
    case (w_next)
      S_WR_PL: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd2; w_wdata = w_period[15:0];
      end
      S_WR_PH: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd3; w_wdata = w_period[31:16];
      end
      S_WR_CTL: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd1;
        w_wdata = w_flag ? 16'h0008 : 16'h0005;
      end
      S_CLR_ST: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd0; w_wdata = 16'h0000;
      end
      S_DONE: begin
        w_done_0 = ~w_grant;
        w_done_1 = w_grant;
        w_err    = w_flag;
      end
      default: begin
        w_cs = 1'b0;
      end
    endcase
  end

  assign done_0         = r_done_0;
  assign done_1         = r_done_1;
  assign err            = r_err;
  assign busy           = r_busy;
  assign tmr_chipselect = r_cs;
  assign tmr_write_n    = r_wn;
  assign tmr_address    = r_addr;
  assign tmr_writedata  = r_wdata;

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched with a behavioural interval-timer model.
module tb_timer_sched;
  localparam int MIN_P = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_0 = 1'b0, req_1 = 1'b0;
  logic [31:0] period_0 = 32'd0, period_1 = 32'd0;
  logic        done_0, done_1, err, busy;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;
`ifdef TIMER_SCHED_ABORT_EN
  logic        abort_0 = 1'b0, abort_1 = 1'b0;
`endif

  timer_sched #(.MIN_PERIOD(MIN_P)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_0(req_0), .req_1(req_1), .period_0(period_0), .period_1(period_1),
`ifdef TIMER_SCHED_ABORT_EN
    .abort_0(abort_0), .abort_1(abort_1),
`endif
    .done_0(done_0), .done_1(done_1), .err(err), .busy(busy),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] addr; logic [15:0] data; int cyc; } wr_t;
  typedef struct { int who; int cyc; logic err; } ev_t;
  typedef struct {
    logic r0; logic r1; logic [31:0] p0; logic [31:0] p1;
    int lat0; int lat1; logic e0; logic e1;
  } vec_t;

  wr_t wr_q[$];
  ev_t ev_q[$];
  int  cyc = 0;
  int  err_pulses = 0;
  int  irq_seen = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  // Timer model: irq rises period+1 cycles after the START write
  logic [31:0] tm_period, tm_cnt;
  logic        tm_run;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tm_run <= 1'b0; tm_cnt <= 32'd0; tmr_irq <= 1'b0; tm_period <= 32'd0;
    end else if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: tmr_irq <= 1'b0;
        3'd1: begin
          if (tmr_writedata[3]) tm_run <= 1'b0;
          else if (tmr_writedata[2]) begin tm_run <= 1'b1; tm_cnt <= tm_period; end
        end
        3'd2: tm_period[15:0]  <= tmr_writedata;
        3'd3: tm_period[31:16] <= tmr_writedata;
        default: ;
      endcase
    end else if (tm_run) begin
      if (tm_cnt == 32'd1) begin tmr_irq <= 1'b1; tm_run <= 1'b0; end
      else tm_cnt <= tm_cnt - 32'd1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Bus and completion monitor
  always @(negedge clk) begin
    if (tmr_chipselect && !tmr_write_n) wr_q.push_back('{tmr_address, tmr_writedata, cyc});
    if (done_0) ev_q.push_back('{0, cyc, err});
    if (done_1) ev_q.push_back('{1, cyc, err});
    if (err) err_pulses <= err_pulses + 1;
    if (tmr_irq) irq_seen <= irq_seen + 1;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int wb, eb, pb, t0, n_exp, budget, b, nsrv;
    logic [31:0] srv[$];
    logic [2:0]  ea[4];
    logic [15:0] ed[4];
    wb = wr_q.size(); eb = ev_q.size(); pb = err_pulses;
    @(negedge clk);
    req_0 = v.r0; req_1 = v.r1; period_0 = v.p0; period_1 = v.p1; t0 = cyc;
    n_exp  = int'(v.r0) + int'(v.r1);
    budget = 200 + (v.r0 ? int'(v.p0) : 0) + (v.r1 ? int'(v.p1) : 0);
    for (int i = 0; i < budget && (ev_q.size() - eb) < n_exp; i++) begin
      @(negedge clk); #1;
      if (done_0) req_0 = 1'b0;
      if (done_1) req_1 = 1'b0;
    end
    req_0 = 1'b0; req_1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_ndone"}, ev_q.size() - eb, n_exp);
    check({tag, "_busy_idle"}, busy, 1'b0);
    for (int i = eb; i < ev_q.size(); i++) begin
      if (ev_q[i].who == 0) begin
        check({tag, "_lat0"}, ev_q[i].cyc - t0, v.lat0);
        check({tag, "_err0"}, ev_q[i].err, v.e0);
      end else begin
        check({tag, "_lat1"}, ev_q[i].cyc - t0, v.lat1);
        check({tag, "_err1"}, ev_q[i].err, v.e1);
      end
    end
    check({tag, "_err_pulses"}, err_pulses - pb, int'(v.r0 && v.e0) + int'(v.r1 && v.e1));
    if (v.r0 && v.p0 >= 32'(MIN_P)) srv.push_back(v.p0);
    if (v.r1 && v.p1 >= 32'(MIN_P)) srv.push_back(v.p1);
    nsrv = srv.size();
    check({tag, "_nwrites"}, wr_q.size() - wb, 4 * nsrv);
    if (wr_q.size() - wb == 4 * nsrv) begin
      for (int g = 0; g < nsrv; g++) begin
        b  = wb + 4 * g;
        ea = '{3'd2, 3'd3, 3'd1, 3'd0};
        ed = '{srv[g][15:0], srv[g][31:16], 16'h0005, 16'h0000};
        for (int k = 0; k < 4; k++) begin
          check({tag, "_wr_addr"}, wr_q[b+k].addr, ea[k]);
          check({tag, "_wr_data"}, wr_q[b+k].data, ed[k]);
        end
        check({tag, "_wr_consec1"}, wr_q[b+1].cyc - wr_q[b].cyc, 1);
        check({tag, "_wr_consec2"}, wr_q[b+2].cyc - wr_q[b].cyc, 2);
      end
    end
  endtask

  vec_t vecs[8];
  vec_t v;
  int   wb, eb, t0, ta;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_cs", tmr_chipselect, 1'b0);
    check("rst_wn", tmr_write_n, 1'b1);
    check("rst_addr", tmr_address, 3'd0);
    check("rst_wdata", tmr_writedata, 16'd0);
    check("rst_done", {done_0, done_1}, 2'b00);
    check("rst_err", err, 1'b0);
    reset_n = 1'b1;

    // Order matters: the round-robin pointer carries between vectors
    vecs[0] = '{1'b1, 1'b0, 32'h0001_0010, 32'h0, 32'h10017, -1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h1, -1, 2, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 32'h5, 32'h5, 12, 25, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h2, 32'h0, 9, -1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h0, 32'h0, 2, -1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h0, 32'h100, -1, 263, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 32'h1, 32'h3, 2, 13, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'h3, 32'h3, 10, 21, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset while waiting on the timer; req_0 drops first and must not abort
    wb = wr_q.size();
    @(negedge clk); req_0 = 1'b1; period_0 = 32'd100;
    for (int i = 0; i < 50 && (wr_q.size() - wb) < 3; i++) @(negedge clk);
    @(negedge clk); req_0 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midop_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_cs", tmr_chipselect, 1'b0);
    check("midrst_wn", tmr_write_n, 1'b1);
    check("midrst_addr", tmr_address, 3'd0);
    check("midrst_wdata", tmr_writedata, 16'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("midrst_nwrites", wr_q.size() - wb, 3);
    v = '{1'b1, 1'b1, 32'h4, 32'h4, 11, 23, 1'b0, 1'b0};
    run_vec("post_rst", v);

    // Fairness: req_0 held through its done while req_1 waits
    eb = ev_q.size();
    @(negedge clk); req_0 = 1'b1; req_1 = 1'b1; period_0 = 32'd3; period_1 = 32'd3; t0 = cyc;
    for (int i = 0; i < 200 && (ev_q.size() - eb) < 3; i++) begin
      @(negedge clk); #1;
      if (done_1) req_1 = 1'b0;
    end
    req_0 = 1'b0; req_1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rr_ndone", ev_q.size() - eb, 3);
    if (ev_q.size() - eb >= 3) begin
      check("rr_first_who", ev_q[eb].who, 0);
      check("rr_first_lat", ev_q[eb].cyc - t0, 10);
      check("rr_second_who", ev_q[eb+1].who, 1);
      check("rr_second_lat", ev_q[eb+1].cyc - t0, 21);
      check("rr_third_who", ev_q[eb+2].who, 0);
      check("rr_third_lat", ev_q[eb+2].cyc - t0, 32);
    end

`ifdef TIMER_SCHED_ABORT_EN
    wb = wr_q.size(); eb = ev_q.size();
    @(negedge clk); req_0 = 1'b1; period_0 = 32'd1000;
    for (int i = 0; i < 50 && (wr_q.size() - wb) < 3; i++) @(negedge clk);
    @(negedge clk); abort_1 = 1'b1;
    @(negedge clk); abort_1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort1_ignored_wr", wr_q.size() - wb, 3);
    check("abort1_ignored_busy", busy, 1'b1);
    ta = irq_seen;
    @(negedge clk); abort_0 = 1'b1; t0 = cyc;
    @(negedge clk); abort_0 = 1'b0;
    for (int i = 0; i < 20 && (ev_q.size() - eb) < 1; i++) begin
      @(negedge clk); #1;
      if (done_0) req_0 = 1'b0;
    end
    req_0 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_nwrites", wr_q.size() - wb, 5);
    check("abort_ndone", ev_q.size() - eb, 1);
    if (wr_q.size() - wb >= 5 && ev_q.size() - eb >= 1) begin
      check("abort_stop_addr", wr_q[wb+3].addr, 3'd1);
      check("abort_stop_data", wr_q[wb+3].data, 16'h0008);
      check("abort_stop_cyc", wr_q[wb+3].cyc - t0, 1);
      check("abort_clr_addr", wr_q[wb+4].addr, 3'd0);
      check("abort_clr_data", wr_q[wb+4].data, 16'h0000);
      check("abort_clr_cyc", wr_q[wb+4].cyc - t0, 2);
      check("abort_done_who", ev_q[eb].who, 0);
      check("abort_done_cyc", ev_q[eb].cyc - t0, 3);
      check("abort_done_err", ev_q[eb].err, 1'b1);
    end
    check("abort_no_irq", irq_seen - ta, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
